// File: rtl/ball_link_pkg.sv
// Shared types and constants for the two-board ball link (transmit and receive sides).
package ball_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT_ACK,
    GAP,
    DONE
  } state_t;

  localparam int unsigned PKT_LEN = 7;
  localparam int unsigned IDX_W   = 3;

  localparam logic [7:0]  REG_PTR     = 8'h00;
  localparam logic [5:0]  REG0_MARKER = 6'b000001;

  localparam logic [19:0] BALL_SPEED_SLOW = 20'd600000;
  localparam logic [19:0] BALL_SPEED_FAST = 20'd400000;

  // Peer slave register file image, reg0 sent first.
  typedef struct packed {
    logic [7:0] reg0;
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [7:0] reg3;
    logic [7:0] reg4;
  } ball_pkt_t;

endpackage

// File: rtl/ball_pkt_byte_sel.sv
// Maps a packet byte index onto the I2C byte stream: address, register pointer, reg0..reg4.
module ball_pkt_byte_sel
  import ball_link_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic [IDX_W-1:0] byte_idx,
  input  ball_pkt_t        pkt,
  output logic [7:0]       cmd_byte_c,
  output logic             cmd_first_c,
  output logic             cmd_last_c
);

  always_comb begin
    cmd_byte_c  = 8'h00;
    cmd_first_c = 1'b0;
    cmd_last_c  = 1'b0;
    case (byte_idx)
      3'd0: begin
        cmd_byte_c  = {SLAVE_ADDR, 1'b0};
        cmd_first_c = 1'b1;
      end
      3'd1: cmd_byte_c = REG_PTR;
      3'd2: cmd_byte_c = pkt.reg0;
      3'd3: cmd_byte_c = pkt.reg1;
      3'd4: cmd_byte_c = pkt.reg2;
      3'd5: cmd_byte_c = pkt.reg3;
      3'd6: begin
        cmd_byte_c = pkt.reg4;
        cmd_last_c = 1'b1;
      end
      default: cmd_byte_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/ball_i2c_packet_tx.sv
// Captures ball state on a trigger edge and sends it as a 7-byte I2C write with NACK retries.
module ball_i2c_packet_tx
  import ball_link_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned RETRY_GAP  = 2500
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       ball_fast,
  input  logic       abort,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_byte,
  output logic       cmd_first,
  output logic       cmd_last,
  input  logic       byte_done,
  input  logic       byte_nack,
  output logic       is_i2c_master_done,
  output logic       send_err,
  output logic       busy
);

  localparam int unsigned GAP_W   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  state_t               state_q, state_d;
  logic                 trig_q;
  ball_pkt_t            pkt_q, pkt_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d, load_idx_c;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 cmd_valid_d, cmd_first_d, cmd_last_d;
  logic [7:0]           cmd_byte_d;
  logic                 done_d, send_err_d, busy_d;
  logic                 load_byte;
  logic [7:0]           sel_byte_c;
  logic                 sel_first_c, sel_last_c;

  // A byte is only ever loaded as the first of an attempt or the successor of an ACKed one.
  always_comb begin
    load_idx_c = '0;
    if (state_q == WAIT_ACK) load_idx_c = byte_idx_q + IDX_W'(1);
  end

  ball_pkt_byte_sel #(
    .SLAVE_ADDR (SLAVE_ADDR)
  ) u_byte_sel (
    .byte_idx    (load_idx_c),
    .pkt         (pkt_q),
    .cmd_byte_c  (sel_byte_c),
    .cmd_first_c (sel_first_c),
    .cmd_last_c  (sel_last_c)
  );

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      trig_q             <= 1'b0;
      pkt_q              <= '0;
      byte_idx_q         <= '0;
      retry_q            <= '0;
      gap_q              <= '0;
      cmd_valid          <= 1'b0;
      cmd_byte           <= 8'h00;
      cmd_first          <= 1'b0;
      cmd_last           <= 1'b0;
      is_i2c_master_done <= 1'b0;
      send_err           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      trig_q             <= ball_send_trigger;
      pkt_q              <= pkt_d;
      byte_idx_q         <= byte_idx_d;
      retry_q            <= retry_d;
      gap_q              <= gap_d;
      cmd_valid          <= cmd_valid_d;
      cmd_byte           <= cmd_byte_d;
      cmd_first          <= cmd_first_d;
      cmd_last           <= cmd_last_d;
      is_i2c_master_done <= done_d;
      send_err           <= send_err_d;
      busy               <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    byte_idx_d  = byte_idx_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    cmd_valid_d = cmd_valid;
    cmd_byte_d  = cmd_byte;
    cmd_first_d = cmd_first;
    cmd_last_d  = cmd_last;
    done_d      = 1'b0;
    send_err_d  = send_err;
    load_byte   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ball_send_trigger && !trig_q) begin
          state_d    = LATCH;
          retry_d    = '0;
          send_err_d = 1'b0;
        end
      end
      LATCH: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          pkt_d.reg0 = {ball_y[9:8], REG0_MARKER};
          pkt_d.reg1 = ball_y[7:0];
          pkt_d.reg2 = ball_vy;
          pkt_d.reg3 = {6'b0, gravity_counter};
          pkt_d.reg4 = {7'b0, ball_fast};
          byte_idx_d = '0;
          load_byte  = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        // A byte the master takes this cycle wins over a simultaneous abort.
        if (cmd_valid && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_ACK;
        end else if (abort && (byte_idx_q == '0)) begin
          cmd_valid_d = 1'b0;
          cmd_first_d = 1'b0;
          state_d     = IDLE;
        end
      end
      WAIT_ACK: begin
        if (byte_done) begin
          if (!byte_nack) begin
            if (byte_idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              byte_idx_d = load_idx_c;
              load_byte  = 1'b1;
              state_d    = SEND;
            end
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            gap_d   = GAP_W'(RETRY_GAP - 1);
            state_d = GAP;
          end else begin
            send_err_d = 1'b1;
            done_d     = 1'b1;
            state_d    = DONE;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          byte_idx_d = '0;
          load_byte  = 1'b1;
          state_d    = SEND;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_byte) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = sel_byte_c;
      cmd_first_d = sel_first_c;
      cmd_last_d  = sel_last_c;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/ball_i2c_packet_tx.md
# ball_i2c_packet_tx

Sits downstream of the two-board game controller. On each rising edge of `ball_send_trigger` it captures the outgoing ball state: y position, vertical velocity, gravity phase and speed class. It serialises that state as a 7-byte I2C write into the peer board's slave register file (reg0..reg4). It drives a byte-level command interface into the I2C master and returns a one-cycle `is_i2c_master_done` pulse. That pulse releases the controller from its send state.

## Interface
Parameters:
- `SLAVE_ADDR`, default 7'h42: peer board 7-bit I2C address.
- `MAX_RETRY`, default 3: number of re-sends after a NACK before giving up.
- `RETRY_GAP`, default 2500: idle cycles between a NACK and the next attempt (100 µs at 25 MHz).

Ports:
- `clk_25MHZ`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `ball_send_trigger`  in  1: level from the controller; high while a send is requested.
- `ball_y`  in  10: ball y position, captured.
- `ball_vy`  in  8: signed vertical velocity, captured.
- `gravity_counter`  in  2: gravity phase, captured.
- `ball_fast`  in  1: 1 when ball speed is 400000, 0 when it is 600000; captured.
- `abort`  in  1: cancel a pending or retrying send (driven from `game_start`).
- `cmd_valid`  out  1: byte command is valid.
- `cmd_ready`  in  1: the master accepts the byte.
- `cmd_byte`  out  8: byte to transmit.
- `cmd_first`  out  1: the master issues START before this byte.
- `cmd_last`  out  1: the master issues STOP after this byte.
- `byte_done`  in  1: one-cycle pulse; the byte's ACK slot has completed.
- `byte_nack`  in  1: qualifies `byte_done`; 1 means NACK. On NACK the master issues STOP itself.
- `is_i2c_master_done`  out  1: one-cycle pulse when the transaction has ended, whether it succeeded or failed.
- `send_err`  out  1: sticky; 1 if the last transaction exhausted its retries. Cleared on the next accepted trigger.
- `busy`  out  1: high in every state except IDLE.

## Operation
The FSM has six states: IDLE, LATCH, SEND, WAIT_ACK, GAP, DONE.

- **IDLE**
  - A rising edge of the trigger is detected using a registered copy of `ball_send_trigger`.
  - On that edge: go to LATCH, set retry_cnt=0, clear `send_err`.
  - If the trigger stays high, it does not retrigger.
- **LATCH**
  - Capture the packet registers:
    - reg0 = {ball_y[9:8], 6'b000001}. The low 6 bits are a fixed marker.
    - reg1 = ball_y[7:0].
    - reg2 = ball_vy.
    - reg3 = {6'b0, gravity_counter}.
    - reg4 = {7'b0, ball_fast}.
  - Set byte_idx=0 and go to SEND.
- **SEND**
  - Assert `cmd_valid`. `cmd_byte` is selected by byte_idx:
    - 0: {SLAVE_ADDR, 1'b0}, with `cmd_first`=1.
    - 1: 8'h00, the register pointer.
    - 2..6: reg0..reg4. `cmd_last`=1 at byte 6.
  - When `cmd_valid` && `cmd_ready` are both high, go to WAIT_ACK.
- **WAIT_ACK**
  - Wait for `byte_done`.
  - ACK with byte_idx<6: byte_idx+1, go to SEND.
  - ACK with byte_idx=6: go to DONE.
  - NACK with retry_cnt<MAX_RETRY: retry_cnt+1, load the gap counter with RETRY_GAP-1, go to GAP.
  - NACK with retry_cnt=MAX_RETRY: set `send_err`=1, go to DONE.
- **GAP**
  - Count down the gap counter.
  - At 0: byte_idx=0, go to SEND. The latched data is reused and not recaptured.
- **DONE**
  - Drive `is_i2c_master_done`=1 for exactly one cycle, then go to IDLE.

Abort:
- Honoured in LATCH, in GAP, and in SEND while byte_idx=0 and the byte has not yet been accepted.
- When honoured: go to IDLE next cycle, with no done pulse and `send_err` unchanged.
- Once byte 0 has been accepted on the current attempt, abort is ignored and the attempt runs to ACK or NACK.

Other rules:
- Outputs `cmd_valid`, `cmd_byte`, `cmd_first` and `cmd_last` are registered and held stable until the handshake completes.
- A `byte_done` outside WAIT_ACK is ignored.
- Reset mid-transaction returns the FSM to IDLE immediately. Recovery of the bus is the master's responsibility.

## Timing
- Reset values:
  - `cmd_valid`, `cmd_first`, `cmd_last`, `is_i2c_master_done`, `send_err`, `busy` = 0.
  - `cmd_byte` = 8'h00.
  - Packet registers, byte_idx, retry_cnt and the gap counter = 0.
  - FSM in IDLE.
- Trigger high first sampled at edge N: LATCH in cycle N+1, `cmd_valid` for byte 0 in cycle N+2.
- Handshake at edge H: `cmd_valid`=0 from H+1. The next byte's `cmd_valid` appears 1 cycle after the `byte_done` edge.
- Final ACK `byte_done` at edge M: done pulse in cycle M+1 and `busy`=0 in cycle M+2.
- Done on the NACK path: NACK edge K, then RETRY_GAP GAP cycles, then `cmd_valid` for byte 0 again.
- Gap counter width is $clog2(RETRY_GAP) bits. retry_cnt width is $clog2(MAX_RETRY+1) bits.

## Structure
- Package `ball_link_pkg` holds:
  - the state_t enum;
  - PKT_LEN=7 and REG_PTR=8'h00;
  - REG0_MARKER=6'b000001;
  - the speed constants 20'd600000 and 20'd400000, shared with the receive-side decode.
- One combinational sub-module, `ball_pkt_byte_sel`, maps byte_idx and the packet registers to cmd_byte, cmd_first and cmd_last.

## Test plan
- Nominal send:
  - Stimulus: y=10'h1A5, vy=-3, gravity=2, fast=1, all ACK.
  - Required: bytes 84,00,41,A5,FD,02,01; `cmd_first` only on 84; `cmd_last` only on 01; exactly one done pulse; `send_err`=0.
- Held trigger:
  - Stimulus: hold the trigger high 20000 cycles after done.
  - Required: no second transaction.
  - Stimulus: drop the trigger, then re-raise it.
  - Required: a new transaction with freshly captured data.
- One NACK, then recovery:
  - Stimulus: NACK on byte 3 of the first attempt.
  - Required: 2500 idle cycles, then a full resend starting at 84; done pulse; `send_err`=0.
- Retries exhausted:
  - Stimulus: NACK on byte 0 on four consecutive attempts.
  - Required: done pulse after the 4th NACK; `send_err`=1; it clears at the next trigger edge.
- Abort:
  - Stimulus: abort during GAP.
  - Required: IDLE next cycle, no done pulse.
  - Stimulus: abort after byte 0 has been accepted.
  - Required: ignored; the transaction completes.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT_ACK of byte 4.
  - Required: all outputs at their reset values asynchronously; no done pulse after release.
